// File: rtl/alarm_ringer.sv
// ---------------------------------------------------------------------------
// alarm_ringer
//   Turns the level "clock time == alarm time" match into a timed, pulsing
//   buzzer drive. Ringing lasts RING_SECS sec ticks, and the buzzer is on for
//   one second and off for the next. The user can stop the alarm, disarm it,
//   or snooze it. A snooze lasts SNOOZE_SECS sec ticks and then rings again.
//   The 1 Hz sec tick is the only timebase. The buttons arrive already
//   debounced as levels, and only their rising edges act.
//
// Optional feature macro: ALARM_SNOOZE_EN
//   defined   : the snooze button moves RING into SNOOZE.
//   undefined : the snooze port is ignored, SNOOZE is never entered, and
//               snoozed is tied low.
//
// Ports
//   ck       in  1  system clock
//   reset    in  1  synchronous, active-high reset
//   sec      in  1  one-cycle 1 Hz tick
//   match    in  1  level: time equals alarm time
//   armed    in  1  level: alarm enable switch
//   stop     in  1  level: stop button
//   snooze   in  1  level: snooze button
//   buzz     out 1  buzzer drive, 1 s on / 1 s off while ringing
//   ringing  out 1  high while in RING
//   snoozed  out 1  high while in SNOOZE
// ---------------------------------------------------------------------------
module alarm_ringer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic ck,
  input  logic reset,
  input  logic sec,
  input  logic match,
  input  logic armed,
  input  logic stop,
  input  logic snooze,
  output logic buzz,
  output logic ringing,
  output logic snoozed
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam int RW = $clog2(RING_SECS);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);

  state_t        state, state_n;
  logic [RW-1:0] ring_cnt, ring_cnt_n;
  logic          phase, phase_n;
  logic          match_q, stop_q;
  logic          match_rise, stop_rise, exit_req;

  // Edge detectors. The delayed copies reset high, so a level that is
  // already asserted when reset is released does not count as a press or
  // a match.
  always_ff @(posedge ck) begin
    if (reset) begin
      match_q <= 1'b1;
      stop_q  <= 1'b1;
    end else begin
      match_q <= match;
      stop_q  <= stop;
    end
  end

  assign match_rise = match & ~match_q;
  assign stop_rise  = stop & ~stop_q;
  // A stop press or a disarm beats every other event in the same cycle.
  assign exit_req   = stop_rise | ~armed;

`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_SECS);
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SECS - 1);

  logic [SW-1:0] snz_cnt, snz_cnt_n;
  logic          snooze_q, snooze_rise;

  assign snooze_rise = snooze & ~snooze_q;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  // Next-state logic. Counters move only on sec ticks. A tick that coincides
  // with a state change is swallowed by that change, because the transitions
  // are tested before the tick.
  always_comb begin
    state_n    = state;
    ring_cnt_n = ring_cnt;
    phase_n    = phase;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_n  = snz_cnt;
`endif
    case (state)
      IDLE: begin
        if (!exit_req && match_rise) begin
          state_n    = RING;
          ring_cnt_n = '0;
          phase_n    = 1'b1;
        end
      end
      RING: begin
        if (exit_req) begin
          state_n = IDLE;
          phase_n = 1'b0;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze_rise) begin
          state_n   = SNOOZE;
          snz_cnt_n = '0;
          phase_n   = 1'b0;
`endif
        end else if (sec) begin
          if (ring_cnt == RING_LAST) begin
            state_n = IDLE;
            phase_n = 1'b0;
          end else begin
            ring_cnt_n = ring_cnt + RW'(1);
            phase_n    = ~phase;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (exit_req) begin
          state_n = IDLE;
        end else if (sec) begin
          if (snz_cnt == SNOOZE_LAST) begin
            state_n    = RING;
            ring_cnt_n = '0;
            phase_n    = 1'b1;
          end else begin
            snz_cnt_n = snz_cnt + SW'(1);
          end
        end
      end
`endif
      default: begin
        state_n = IDLE;
        phase_n = 1'b0;
      end
    endcase
  end

  // State, counters and the registered outputs. The outputs are derived
  // from the next state, so ringing and buzz appear one cycle after the
  // match edge and drop together on exit.
  always_ff @(posedge ck) begin
    if (reset) begin
      state    <= IDLE;
      ring_cnt <= '0;
      phase    <= 1'b0;
      ringing  <= 1'b0;
      buzz     <= 1'b0;
    end else begin
      state    <= state_n;
      ring_cnt <= ring_cnt_n;
      phase    <= phase_n;
      ringing  <= (state_n == RING);
      buzz     <= (state_n == RING) & phase_n;
    end
  end

`ifdef ALARM_SNOOZE_EN
  // Snooze-only registers.
  always_ff @(posedge ck) begin
    if (reset) begin
      snz_cnt  <= '0;
      snooze_q <= 1'b1;
      snoozed  <= 1'b0;
    end else begin
      snz_cnt  <= snz_cnt_n;
      snooze_q <= snooze;
      snoozed  <= (state_n == SNOOZE);
    end
  end
`else
  assign snoozed = 1'b0;
`endif

endmodule
